// File: rtl/quadrant_scanner.sv
// rtl/quadrant_scanner.sv - tile-ordered pixel address generator
// Walks the image QUAD x QUAD tile by tile and issues addresses over a valid/ready handshake.
module quadrant_scanner #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16,
  parameter int QUAD   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_img_width,
  input  logic [DIM_W-1:0]  i_img_height,
  input  logic              i_pix_ready,
  output logic              o_pix_valid,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [7:0]        o_quad_idx,
  output logic              o_quad_done,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int QLOG = (QUAD > 1) ? $clog2(QUAD) : 1;
  localparam int EW   = DIM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIM_W-1:0]  r_w, r_h;
  logic [DIM_W-1:0]  r_bx, r_by, r_x, r_y;
  logic [QLOG-1:0]   r_lx, r_ly;
  logic [ADDR_W-1:0] r_band_base, r_row_base, r_addr;
  logic [7:0]        r_quad_idx;
  logic              r_quad_done;

  logic              w_start_acc, w_hs;
  logic              w_last_col, w_last_row, w_last_tile_in_band, w_last_band;
  logic              w_tile_end, w_frame_end;
  logic [ADDR_W-1:0] w_w_addr, w_band_stride, w_next_band_base;
  logic [DIM_W-1:0]  w_next_bx;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_hs        = (r_state == S_SCAN) && i_pix_ready;

  // Local tile counters bound the tile at QUAD; the image edge clips it earlier.
  assign w_last_col = (r_lx == QLOG'(QUAD - 1)) ||
                      ((EW'(r_x) + EW'(1)) >= EW'(r_w));
  assign w_last_row = (r_ly == QLOG'(QUAD - 1)) ||
                      ((EW'(r_y) + EW'(1)) >= EW'(r_h));
  assign w_last_tile_in_band = (EW'(r_bx) + EW'(QUAD)) >= EW'(r_w);
  assign w_last_band         = (EW'(r_by) + EW'(QUAD)) >= EW'(r_h);
  assign w_tile_end  = w_last_col && w_last_row;
  assign w_frame_end = w_tile_end && w_last_tile_in_band && w_last_band;

  assign w_w_addr         = ADDR_W'(r_w);
  assign w_band_stride    = w_w_addr << QLOG;
  assign w_next_band_base = r_band_base + w_band_stride;
  assign w_next_bx        = r_bx + DIM_W'(QUAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_pix_valid  = 1'b0;
    o_frame_done = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if ((i_img_width == '0) || (i_img_height == '0)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        o_pix_valid = 1'b1;
        if (i_pix_ready && w_frame_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address tracks row_base + x incrementally; band_base is the first row of the tile band.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w         <= '0;
      r_h         <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_lx        <= '0;
      r_ly        <= '0;
      r_band_base <= '0;
      r_row_base  <= '0;
      r_addr      <= '0;
      r_quad_idx  <= '0;
      r_quad_done <= 1'b0;
    end else begin
      r_quad_done <= 1'b0;
      if (w_start_acc) begin
        r_w         <= i_img_width;
        r_h         <= i_img_height;
        r_bx        <= '0;
        r_by        <= '0;
        r_x         <= '0;
        r_y         <= '0;
        r_lx        <= '0;
        r_ly        <= '0;
        r_band_base <= '0;
        r_row_base  <= '0;
        r_addr      <= '0;
        r_quad_idx  <= '0;
      end else if (w_hs) begin
        if (!w_last_col) begin
          r_x    <= r_x + 1'b1;
          r_lx   <= r_lx + 1'b1;
          r_addr <= r_addr + 1'b1;
        end else if (!w_last_row) begin
          r_x        <= r_bx;
          r_lx       <= '0;
          r_y        <= r_y + 1'b1;
          r_ly       <= r_ly + 1'b1;
          r_row_base <= r_row_base + w_w_addr;
          r_addr     <= r_row_base + w_w_addr + ADDR_W'(r_bx);
        end else begin
          r_quad_done <= 1'b1;
          r_quad_idx  <= r_quad_idx + 1'b1;
          r_lx        <= '0;
          r_ly        <= '0;
          if (!w_last_tile_in_band) begin
            r_bx       <= w_next_bx;
            r_x        <= w_next_bx;
            r_y        <= r_by;
            r_row_base <= r_band_base;
            r_addr     <= r_band_base + ADDR_W'(w_next_bx);
          end else begin
            r_bx        <= '0;
            r_x         <= '0;
            r_by        <= r_by + DIM_W'(QUAD);
            r_y         <= r_by + DIM_W'(QUAD);
            r_band_base <= w_next_band_base;
            r_row_base  <= w_next_band_base;
            r_addr      <= w_next_band_base;
          end
        end
      end
    end
  end

  assign o_pix_addr  = r_addr;
  assign o_quad_idx  = r_quad_idx;
  assign o_quad_done = r_quad_done;

endmodule

// File: tb/tb_quadrant_scanner.sv
// tb/tb_quadrant_scanner.sv - scoreboard bench for quadrant_scanner
// Expected addresses come from a behavioural tile walk pushed at start and popped per handshake.
module tb_quadrant_scanner;

  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;
  localparam int QUAD   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  img_w = '0;
  logic [DIM_W-1:0]  img_h = '0;
  logic              pix_ready = 1'b0;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        quad_idx;
  logic              quad_done;
  logic              frame_done;
  logic              busy;

  quadrant_scanner #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .QUAD(QUAD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_img_width  (img_w),
    .i_img_height (img_h),
    .i_pix_ready  (pix_ready),
    .o_pix_valid  (pix_valid),
    .o_pix_addr   (pix_addr),
    .o_quad_idx   (quad_idx),
    .o_quad_done  (quad_done),
    .o_frame_done (frame_done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                last;
    logic [7:0]        qi;
  } exp_t;

  exp_t sb[$];
  int   n_tiles;
  bit   mon_en = 1'b0;
  bit   exp_qd = 1'b0;
  bit   exp_fd = 1'b0;
  int   hs_cnt = 0;
  int   qd_cnt = 0;

  task automatic build_model(input int w, input int h);
    int t;
    exp_t e;
    t = 0;
    sb.delete();
    for (int by = 0; by < h; by += QUAD) begin
      for (int bx = 0; bx < w; bx += QUAD) begin
        int ye;
        int xe;
        ye = (by + QUAD < h) ? by + QUAD : h;
        xe = (bx + QUAD < w) ? bx + QUAD : w;
        for (int y = by; y < ye; y++) begin
          for (int x = bx; x < xe; x++) begin
            e.addr = ADDR_W'(y * w + x);
            e.last = (y == ye - 1) && (x == xe - 1);
            e.qi   = 8'(t);
            sb.push_back(e);
          end
        end
        t++;
      end
    end
    n_tiles = t;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      expect_eq("quad_done", quad_done, exp_qd);
      expect_eq("frame_done", frame_done, exp_fd);
      if (quad_done) qd_cnt++;
      exp_qd = 1'b0;
      exp_fd = 1'b0;
      if (pix_valid && pix_ready) begin
        expect_eq("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          expect_eq("pix_addr", pix_addr, e.addr);
          expect_eq("quad_idx", quad_idx, e.qi);
          exp_qd = e.last;
          exp_fd = e.last && (sb.size() == 0);
          hs_cnt++;
        end
      end
    end
  end

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_frame(input int w, input int h, input int mode, input bit hold_start);
    bit seen;
    int cyc;
    build_model(w, h);
    hs_cnt = 0;
    qd_cnt = 0;
    exp_qd = 1'b0;
    exp_fd = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    img_w = DIM_W'(w);
    img_h = DIM_W'(h);
    start = 1'b1;
    pix_ready = ready_pat(mode, 0);
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    expect_eq("first_valid", pix_valid, 1);
    expect_eq("busy_scan", busy, 1);
    seen = 1'b0;
    cyc = 1;
    while (!seen && cyc < 20000) begin
      @(posedge clk); #1;
      pix_ready = ready_pat(mode, cyc);
      cyc++;
      if (frame_done) begin
        seen = 1'b1;
        start = 1'b0;
        expect_eq("busy_done", busy, 1);
        expect_eq("valid_done", pix_valid, 0);
      end
    end
    expect_eq("frame_seen", seen, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    expect_eq("busy_idle", busy, 0);
    expect_eq("valid_idle", pix_valid, 0);
    expect_eq("sb_left", sb.size(), 0);
    expect_eq("quad_count", qd_cnt, n_tiles);
    expect_eq("quad_idx_end", quad_idx, n_tiles % 256);
  endtask

  task automatic zero_dim(input int w, input int h);
    @(posedge clk); #1;
    img_w = DIM_W'(w);
    img_h = DIM_W'(h);
    start = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect_eq("zd_frame_done", frame_done, 1);
    expect_eq("zd_quad_done", quad_done, 0);
    expect_eq("zd_valid", pix_valid, 0);
    expect_eq("zd_busy", busy, 1);
    @(posedge clk); #1;
    expect_eq("zd_idle_busy", busy, 0);
    expect_eq("zd_idle_fd", frame_done, 0);
    expect_eq("zd_idle_valid", pix_valid, 0);
  endtask

  task automatic reset_abort();
    int c;
    build_model(4, 4);
    hs_cnt = 0;
    exp_qd = 1'b0;
    exp_fd = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    img_w = 8'd4;
    img_h = 8'd4;
    start = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (hs_cnt < 5 && c < 100) begin
      @(negedge clk);
      c++;
    end
    expect_eq("abort_hs", hs_cnt, 5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    mon_en = 1'b0;
    sb.delete();
    expect_eq("abort_valid", pix_valid, 0);
    expect_eq("abort_addr", pix_addr, 0);
    expect_eq("abort_qidx", quad_idx, 0);
    expect_eq("abort_qd", quad_done, 0);
    expect_eq("abort_fd", frame_done, 0);
    expect_eq("abort_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    expect_eq("rst_valid", pix_valid, 0);
    expect_eq("rst_addr", pix_addr, 0);
    expect_eq("rst_qidx", quad_idx, 0);
    expect_eq("rst_qd", quad_done, 0);
    expect_eq("rst_fd", frame_done, 0);
    expect_eq("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(4, 4, 0, 1'b0);
    run_frame(8, 4, 0, 1'b0);
    run_frame(6, 6, 0, 1'b1);
    run_frame(4, 4, 1, 1'b0);
    zero_dim(0, 5);
    zero_dim(3, 0);
    reset_abort();
    run_frame(4, 4, 0, 1'b0);
    run_frame(5, 3, 2, 1'b0);
    run_frame(13, 9, 1, 1'b0);
    run_frame(64, 64, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
